// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns byte/half/word requests into word-aligned MEMORY
// accesses, extends load lanes and merges sub-word stores via read-modify-write.
module lsu_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0]      req_wdata_i,
  output logic                  resp_valid_o,
  output logic [WIDTH-1:0]      resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  memread_o,
  output logic                  memwrite_o,
  output logic [ADDR_WIDTH-1:0] memaddr_o,
  output logic [WIDTH-1:0]      memwdata_o,
  input  logic [WIDTH-1:0]      memrdata_i
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [2:0]            state;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [WIDTH-1:0]      merge_q;
  logic [WIDTH-1:0]      rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  req_err;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [WIDTH-1:0]      load_ext;
  logic [WIDTH-1:0]      merged;

  assign accept = req_valid_i && req_ready_o;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = req_addr_i[0];
      SZ_W:    req_err = |req_addr_i[1:0];
      default: req_err = 1'b1;
    endcase
  end

  // Little-endian lane selection off the captured request address.
  always_comb begin
    byte_sel = memrdata_i[{addr_q[1:0], 3'b000} +: 8];
    half_sel = memrdata_i[{addr_q[1], 4'b0000} +: 16];
    load_ext = memrdata_i;
    merged   = memrdata_i;
    case (size_q)
      SZ_B: begin
        load_ext = {{(WIDTH-8){~uns_q & byte_sel[7]}}, byte_sel};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_H: begin
        load_ext = {{(WIDTH-16){~uns_q & half_sel[15]}}, half_sel};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: begin
        load_ext = memrdata_i;
        merged   = memrdata_i;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i[15:0];
            merge_q <= req_wdata_i;
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err)                             state <= RESP;
            else if (req_we_i && req_size_i == SZ_W) state <= WR;
            else                                     state <= RD;
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (we_q) begin
            merge_q <= merged;
            state   <= WR;
          end else begin
            rdata_q <= load_ext;
            state   <= RESP;
          end
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so an aborted write never reaches MEMORY.
  assign req_ready_o  = (state == IDLE) && !rst;
  assign resp_valid_o = (state == RESP) && !rst;
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign resp_err_o   = resp_valid_o && err_q;
  assign memread_o    = (state == RD) && !rst;
  assign memwrite_o   = (state == WR) && !rst;
  assign memaddr_o    = (memread_o || memwrite_o) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign memwdata_o   = memwrite_o ? merge_q : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small word-addressed MEMORY model
// (IROM writes discarded, DRAM at 0x1000-0x1FFF).
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        memread;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwdata;
  logic [31:0] memrdata = 32'h0;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .memread_o      (memread),
    .memwrite_o     (memwrite),
    .memaddr_o      (memaddr),
    .memwdata_o     (memwdata),
    .memrdata_i     (memrdata)
  );

  // Synchronous-read MEMORY model.
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'hAABBCCDD;
      mem[1] <= 32'h8899AABB;
    end
    if (memread) memrdata <= mem[memaddr[11:2]];
    if (memwrite && memaddr >= 32'h1000 && memaddr < 32'h2000)
      mem[memaddr[11:2]] <= memwdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // Issue one request at a negedge and observe 8 cycles after the accept edge.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [31:0] exp_maddr, input logic [31:0] exp_wdata);
    int lat = -1;
    int n_resp = 0, n_rd = 0, n_wr = 0, n_both = 0, n_leak = 0;
    logic [31:0] got_rdata = '0, rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic got_err = 1'b0;
    logic exp_rd, exp_wr;
    exp_rd = !exp_err && !(we && size == 2'b10);
    exp_wr = !exp_err && we;
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    drive_req(we, size, uns, addr, wdata);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (memread)  begin n_rd++; rd_addr = memaddr; end
      if (memwrite) begin n_wr++; wr_addr = memaddr; wr_data = memwdata; end
      if (memread && memwrite) n_both++;
      if (!resp_valid && (resp_rdata != 0 || resp_err)) n_leak++;
      if (resp_valid) begin
        n_resp++;
        if (lat < 0) begin lat = c; got_rdata = resp_rdata; got_err = resp_err; end
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " resp count"}, n_resp, 32'd1);
    check({tag, " rdata"}, got_rdata, exp_rdata);
    check({tag, " err"}, {31'b0, got_err}, {31'b0, exp_err});
    check({tag, " read strobes"}, n_rd, {31'b0, exp_rd});
    check({tag, " write strobes"}, n_wr, {31'b0, exp_wr});
    check({tag, " rd/wr overlap"}, n_both, 32'd0);
    check({tag, " idle leak"}, n_leak, 32'd0);
    if (exp_rd) check({tag, " read addr"}, rd_addr, exp_maddr);
    if (exp_wr) begin
      check({tag, " write addr"}, wr_addr, exp_maddr);
      check({tag, " write data"}, wr_data, exp_wdata);
    end
  endtask

  initial begin
    int rdy [1:8];
    int n_resp_rst;
    int resp1, resp2, rd_cyc, wr_cyc;
    logic [31:0] wdat, rdat2;

    rst = 1'b1; preload = 1'b1;
    drive_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    repeat (3) @(negedge clk);
    check("reset ready", {31'b0, req_ready}, 32'd0);
    check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset strobes", {30'b0, memread, memwrite}, 32'd0);
    check("reset memaddr", memaddr, 32'd0);
    check("reset memwdata", memwdata, 32'd0);
    rst = 1'b0; preload = 1'b0; req_valid = 1'b0;
    @(negedge clk);

    // Loads over word 0x8899AABB.
    do_req("lw 1004",  1'b0, 2'b10, 1'b0, 32'h1004, 0, 3, 1'b0, 32'h8899AABB, 32'h1004, 0);
    do_req("lb 1007",  1'b0, 2'b00, 1'b0, 32'h1007, 0, 3, 1'b0, 32'hFFFFFF88, 32'h1004, 0);
    do_req("lbu 1007", 1'b0, 2'b00, 1'b1, 32'h1007, 0, 3, 1'b0, 32'h00000088, 32'h1004, 0);
    do_req("lhu 1004", 1'b0, 2'b01, 1'b1, 32'h1004, 0, 3, 1'b0, 32'h0000AABB, 32'h1004, 0);
    do_req("lh 1006",  1'b0, 2'b01, 1'b0, 32'h1006, 0, 3, 1'b0, 32'hFFFF8899, 32'h1004, 0);
    do_req("lbu 1005", 1'b0, 2'b00, 1'b1, 32'h1005, 0, 3, 1'b0, 32'h000000AA, 32'h1004, 0);

    // Sub-word RMW store, then read back.
    do_req("sh 1002",  1'b1, 2'b01, 1'b0, 32'h1002, 32'hFFFF1234, 4, 1'b0, 0, 32'h1000, 32'h1234CCDD);
    do_req("lw 1000",  1'b0, 2'b10, 1'b0, 32'h1000, 0, 3, 1'b0, 32'h1234CCDD, 32'h1000, 0);

    // Errors: no memory strobes, one-cycle response.
    do_req("lw 1002",  1'b0, 2'b10, 1'b0, 32'h1002, 0, 1, 1'b1, 0, 0, 0);
    do_req("sh 1001",  1'b1, 2'b01, 1'b0, 32'h1001, 32'h5555, 1, 1'b1, 0, 0, 0);
    do_req("size 11",  1'b0, 2'b11, 1'b0, 32'h1000, 0, 1, 1'b1, 0, 0, 0);

    // Word store into IROM range is issued unchanged with no error.
    do_req("sw irom",  1'b1, 2'b10, 1'b0, 32'h0010, 32'hDEADBEEF, 2, 1'b0, 0, 32'h0010, 32'hDEADBEEF);

    // sb with rst asserted during the WR cycle.
    drive_req(1'b1, 2'b00, 1'b0, 32'h1001, 32'h00000055);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("sb rst RD strobe", {31'b0, memread}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("sb rst WR memwrite", {31'b0, memwrite}, 32'd0);
    check("sb rst WR memaddr", memaddr, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("sb rst ready after", {31'b0, req_ready}, 32'd1);
    n_resp_rst = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid || memwrite) n_resp_rst++;
      @(negedge clk);
    end
    check("sb rst no resp", n_resp_rst, 32'd0);
    do_req("lw after rst", 1'b0, 2'b10, 1'b0, 32'h1000, 0, 3, 1'b0, 32'h1234CCDD, 32'h1000, 0);

    // Back-to-back with req_valid held: sw then lw.
    resp1 = -1; resp2 = -1; rd_cyc = -1; wr_cyc = -1; wdat = '0; rdat2 = '0;
    drive_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h11111111);
    @(posedge clk);
    #1 drive_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rdy[c] = int'(req_ready);
      if (memwrite && wr_cyc < 0) begin wr_cyc = c; wdat = memwdata; end
      if (memread && rd_cyc < 0) rd_cyc = c;
      if (resp_valid) begin
        if (resp1 < 0) resp1 = c;
        else if (resp2 < 0) begin resp2 = c; rdat2 = resp_rdata; end
      end
      if (c == 4) req_valid = 1'b0;
    end
    check("b2b ready c1", rdy[1], 32'd0);
    check("b2b ready c2", rdy[2], 32'd0);
    check("b2b ready c3", rdy[3], 32'd1);
    check("b2b ready c4", rdy[4], 32'd0);
    check("b2b write cycle", wr_cyc, 32'd1);
    check("b2b write data", wdat, 32'h11111111);
    check("b2b first resp", resp1, 32'd2);
    check("b2b read cycle", rd_cyc, 32'd4);
    check("b2b second resp", resp2, 32'd6);
    check("b2b load data", rdat2, 32'h11111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
